// File: rtl/ram_req_pkg.sv
// Shared types and constants for the RAM request master.
package ram_req_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam int RSP_FIFO_DEPTH = 2;

  // Number of RAM words for a given address width.
  function automatic int mem_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_rsp_fifo2.sv
// Two-entry response FIFO: head entry drives the read-data output and
// holds steady until popped.
module ram_rsp_fifo2
  import ram_req_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [RSP_FIFO_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;

  // Storage, pointers and occupancy; push+pop together keep count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ram_req_master.sv
// Valid/ready request front end for a single-port synchronous RAM.
// Reads are absorbed through a 1-cycle RAM latency into a 2-entry
// response FIFO. Define RAM_INIT_CLEAR_EN to zero-fill the RAM after reset.
module ram_req_master
  import ram_req_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_busy,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  logic                  in_init;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_pending;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [1:0]            fifo_count;
  logic [2:0]            occ;

`ifdef RAM_INIT_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(mem_depth(ADDR_WIDTH) - 1);

  state_t state;
  state_t state_nxt;

  // State register and fill counter; fill restarts at address 0 on every reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  // Leave INIT once the last address has been written.
  always_comb begin
    state_nxt = state;
    if (state == INIT && init_cnt == LAST_ADDR) state_nxt = RUN;
  end

  assign in_init   = (state == INIT);
  assign init_busy = in_init;
`else
  assign in_init   = 1'b0;
  assign init_cnt  = '0;
  assign init_busy = 1'b0;
`endif

  // Slots already claimed for the response path, crediting this cycle's pop
  // so a draining consumer lets a new read in on the same cycle.
  assign fifo_pop  = rsp_valid & rsp_ready;
  assign fifo_push = rd_pending;
  assign occ       = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, fifo_pop};

  // RAM port steering: zero-fill during INIT, otherwise pass requests through.
  always_comb begin
    req_ready = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = req_addr;
    ram_din   = req_wdata;
    if (in_init) begin
      ram_we   = 1'b1;
      ram_addr = init_cnt;
      ram_din  = '0;
    end else begin
      req_ready = req_we ? 1'b1 : (occ < 3'd2);
      ram_we    = req_valid & req_ready & req_we;
      ram_re    = req_valid & req_ready & ~req_we;
    end
  end

  // Marks the cycle in which ram_dout carries the data of an accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pending <= 1'b0;
    else        rd_pending <= ram_re;
  end

  ram_rsp_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(ram_dout),
    .pop      (fifo_pop),
    .head_data(rsp_rdata),
    .count    (fifo_count)
  );

  assign rsp_valid = (fifo_count != 2'd0);

endmodule

// File: doc/ram_req_master.md
Name: ram_req_master

Overview:
- Initiator/controller for the single-port synchronous RAM; it is the other end of the RAM's we/re/addr/din/dout port.
- Converts a valid/ready request stream (read or write) into RAM port cycles.
- Absorbs the RAM's 1-cycle read latency and returns read data on a valid/ready response stream with backpressure.
- Optionally zero-fills the whole RAM after reset before accepting requests.

Parameters:
- DATA_WIDTH, 8, RAM word width in bits
- ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  read response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_WIDTH  read data
- init_busy  out  1  zero-fill in progress
- ram_we  out  1  to RAM write enable
- ram_re  out  1  to RAM read enable
- ram_addr  out  ADDR_WIDTH  to RAM address
- ram_din  out  DATA_WIDTH  to RAM write data
- ram_dout  in  DATA_WIDTH  from RAM; valid the cycle after ram_re

Behaviour:
- Reset values (async, rst_n=0): state=INIT if RAM_INIT_CLEAR_EN is defined, else RUN; init counter=0; rd_pending=0; FIFO empty; rsp_valid=0; rsp_rdata=0; init_busy=1 if the feature is enabled, else 0. RAM contents are not reset.
- FSM states:
  - INIT: ram_we=1, ram_re=0, ram_addr=init_cnt, ram_din=0, req_ready=0. init_cnt increments each cycle. When init_cnt = 2**ADDR_WIDTH-1 is written, go to RUN; init_busy falls the cycle after.
  - RUN: ram_addr=req_addr and ram_din=req_wdata, combinationally.
- Write acceptance: req_ready=1 for writes whenever in RUN. ram_we = req_valid & req_ready & req_we. Writes produce no response.
- Read acceptance: let occ = fifo_count + rd_pending - (rsp_valid & rsp_ready). req_ready for a read = (occ < 2). ram_re = req_valid & req_ready & ~req_we.
  - The combinational path rsp_ready -> req_ready is intentional and permits full throughput.
- Read pipeline:
  - Read accepted in cycle N sets rd_pending=1 at the edge ending cycle N.
  - In cycle N+1, ram_dout is pushed into the 2-entry response FIFO.
  - rsp_valid=1 in cycle N+2. Minimum latency is 2 cycles.
  - Responses are returned strictly in request order.
- Response FIFO:
  - Depth 2. rsp_rdata is the head entry; rsp_valid = (count != 0).
  - Push and pop in the same cycle keep the count unchanged.
  - Overflow is impossible by construction. Verification asserts it.
- Read/write ordering: one RAM operation per cycle. A write accepted after a read to the same address never affects that read's data. A read after a write returns the new data.
- Wrap-around: init_cnt wraps to 0 after the last address but is unused afterwards. Address arithmetic is modulo 2**ADDR_WIDTH.
- Reset mid-operation: in-flight reads and buffered responses are discarded. INIT restarts at address 0 when the feature is enabled.
- rsp_rdata holds its value while rsp_valid & ~rsp_ready.

Optional Feature:
- Macro: RAM_INIT_CLEAR_EN
- Defined: the INIT zero-fill FSM is present. After each reset it takes 2**ADDR_WIDTH cycles, with init_busy high and req_ready low.
- Undefined: no INIT state or counter. The block resets directly into RUN, init_busy is tied to 0, and RAM contents are undefined until written.

Decomposition:
- Package ram_req_pkg:
  - state enum (INIT, RUN)
  - RSP_FIFO_DEPTH = 2
  - helper constant MEM_DEPTH = 2**ADDR_WIDTH, as a function or localparam pattern
- Sub-module ram_rsp_fifo2:
  - 2-entry valid/ready FIFO carrying DATA_WIDTH data
  - outputs count, push/pop, head data
  - reset via rst_n

Test Plan:
- Feature on, reset released: init_busy high exactly 16 cycles with ram_we=1 and addresses 0..15 with din=0x00; req_ready=0 throughout. Then reads of addresses 0..15 all return 0x00.
- Write 0xA5 to addr 3, then read addr 3 on the next cycle with rsp_ready=1 -> rsp_valid with rsp_rdata=0xA5 two cycles after read acceptance.
- rsp_ready=1, back-to-back reads of addrs 1,2,3 holding 0x11,0x22,0x33 -> req_ready stays 1; responses 0x11,0x22,0x33 on consecutive cycles.
- rsp_ready=0, issue 3 reads -> first 2 accepted, third sees req_ready=0. Writes still accepted. Raising rsp_ready -> third read accepted; all data returned in order with none lost.
- Assert rst_n mid-INIT at address 7 -> init_busy stays high and the fill restarts at address 0, taking a full 16 cycles.
- Assert rst_n with 2 responses buffered -> rsp_valid=0 immediately and no stale response after reset.
